// File: rtl/modmul_ctrl.sv
// rtl/modmul_ctrl.sv - (A*B) mod N sequencer driving a shared one-op-per-cycle add/sub ALU
// Interleaved MSB-first shift-add with a conditional subtract after each doubling and each add.
module modmul_ctrl #(
    parameter int W  = 32,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic [W-1:0]  n_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [W-1:0]  alu_ext,
    output logic          alu_func,
    output logic          opb_selector,
    input  logic [W-1:0]  alu_result,
    input  logic          alu_c
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DBL,
        S_RED1,
        S_ADDB,
        S_RED2,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  r_q, a_q, b_q, n_q;
    logic [IW-1:0] idx_q;
    logic          done_q, err_q;
    logic [W-1:0]  result_q;
    logic          r_load;
    logic          bad_ops;

    // R < N stays true only if N fits below the top bit and A is already reduced.
    assign bad_ops = (n_in == '0) || n_in[W-1] || (a_in >= n_in);

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_func  = 1'b0;
        r_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = bad_ops ? S_DONE : S_DBL;
            end
            S_DBL: begin
                alu_a     = r_q;
                alu_b     = r_q;
                r_load    = 1'b1;
                state_nxt = S_RED1;
            end
            S_RED1: begin
                alu_a     = r_q;
                alu_b     = n_q;
                alu_func  = 1'b1;
                r_load    = alu_c;
                state_nxt = S_ADDB;
            end
            S_ADDB: begin
                alu_a     = r_q;
                alu_b     = a_q;
                r_load    = b_q[idx_q];
                state_nxt = S_RED2;
            end
            S_RED2: begin
                alu_a     = r_q;
                alu_b     = n_q;
                alu_func  = 1'b1;
                r_load    = alu_c;
                state_nxt = (idx_q == '0) ? S_DONE : S_DBL;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            r_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == S_DONE);
            if (r_load) r_q <= alu_result;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        n_q   <= n_in;
                        r_q   <= '0;
                        idx_q <= IW'(W - 1);
                        err_q <= bad_ops;
                    end
                end
                S_RED2: begin
                    if (idx_q != '0) idx_q <= idx_q - IW'(1);
                end
                S_DONE: begin
                    result_q <= err_q ? '0 : r_q;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state == S_DBL) || (state == S_RED1) ||
                          (state == S_ADDB) || (state == S_RED2);
    assign done         = done_q;
    assign err          = err_q;
    assign result       = result_q;
    assign alu_ext      = '0;
    assign opb_selector = 1'b0;

endmodule

// File: tb/tb_modmul_ctrl.sv
// tb/tb_modmul_ctrl.sv - scoreboard bench for modmul_ctrl with a behavioural ALU and reference model
module tb_modmul_ctrl;

    localparam int W = 32;
    localparam int LAT = 4 * W + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0, b_in = '0, n_in = '0;
    logic          busy, done, err;
    logic [W-1:0]  result, alu_a, alu_b, alu_ext, alu_result;
    logic          alu_func, opb_selector, alu_c;
    logic [W:0]    alu_sum;

    modmul_ctrl #(.W(W), .IW(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_in(a_in), .b_in(b_in), .n_in(n_in),
        .busy(busy), .done(done), .err(err), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ext(alu_ext),
        .alu_func(alu_func), .opb_selector(opb_selector),
        .alu_result(alu_result), .alu_c(alu_c)
    );

    always #5 clk = ~clk;

    // Execute-stage stand-in: add gives carry-out, sub gives "no borrow".
    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = alu_func ? (alu_a - alu_b) : alu_sum[W-1:0];
    assign alu_c      = alu_func ? (alu_a >= alu_b) : alu_sum[W];

    typedef struct { logic [W-1:0] res; logic err; int unsigned done_cyc; } exp_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic f; } op_t;

    exp_t exp_q[$];
    op_t  op_q[$];
    int unsigned cyc = 0;
    int compared = 0;
    int mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: plain arithmetic for the result, and the per-step ALU traffic the
    // state sequence implies (double, reduce, conditional add, reduce per bit of B).
    task automatic push_expect(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
        exp_t e;
        longint unsigned r, nn, aa;
        logic bad;
        bad   = (n == 0) || n[W-1] || (a >= n);
        e.err = bad;
        e.res = bad ? '0 : W'((longint'(a) * longint'(b)) % longint'(n));
        e.done_cyc = cyc + (bad ? 1 : LAT);
        exp_q.push_back(e);
        if (!bad) begin
            r = 0; nn = n; aa = a;
            for (int i = W - 1; i >= 0; i--) begin
                op_q.push_back('{W'(r), W'(r), 1'b0});
                r = 2 * r;
                op_q.push_back('{W'(r), n, 1'b1});
                if (r >= nn) r = r - nn;
                op_q.push_back('{W'(r), a, 1'b0});
                if (b[i]) r = r + aa;
                op_q.push_back('{W'(r), n, 1'b1});
                if (r >= nn) r = r - nn;
            end
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) return;
        end
        fail_now("wait_idle_timeout");
        exp_q.delete();
        op_q.delete();
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] n);
        a_in = a; b_in = b; n_in = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_expect(a, b, n);
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (op_q.size() == 0) fail_now("busy_extra");
                else begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("alu_op", {alu_a, alu_b, alu_func}, {o.a, o.b, o.f});
                end
            end else begin
                if (op_q.size() != 0) begin
                    fail_now("busy_low");
                    op_q.delete();
                end
                chk("alu_idle", {alu_a, alu_b, alu_ext, alu_func, opb_selector}, '0);
            end
            if (done) begin
                if (exp_q.size() == 0) fail_now("spurious_done");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("err", err, e.err);
                    chk("done_latency", cyc, e.done_cyc);
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].done_cyc) begin
                fail_now("done_timeout");
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] a, b, n;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        chk("reset_outs", {busy, done, err, result, alu_a, alu_b, alu_func}, '0);

        issue(32'd5, 32'd7, 32'd11);
        issue(32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        issue(32'h7FFF_FFFE, 32'd2, 32'h7FFF_FFFF);
        issue(32'd0, 32'hDEAD_BEEF, 32'h1234_5677);
        issue(32'd3, 32'd5, 32'd0);
        issue(32'd3, 32'd5, 32'h8000_0001);
        issue(32'd11, 32'd5, 32'd11);
        issue(32'd10, 32'd10, 32'd11);

        // Start held high with operands churning; only the accept-cycle values count.
        a_in = 32'd123; b_in = 32'd456; n_in = 32'd1000; start = 1'b1;
        @(posedge clk); #1;
        push_expect(32'd123, 32'd456, 32'd1000);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) break;
            a_in = $urandom; b_in = $urandom; n_in = $urandom;
        end
        a_in = 32'd77; b_in = 32'hCAFE_F00D; n_in = 32'd99991;
        @(posedge clk); #1;
        push_expect(32'd77, 32'hCAFE_F00D, 32'd99991);
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a run aborts with no done pulse.
        a_in = 32'd9; b_in = 32'd13; n_in = 32'd17; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_expect(32'd9, 32'd13, 32'd17);
        repeat (39) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        op_q.delete();
        @(negedge clk); #1;
        chk("abort_outs", {busy, done, result}, '0);
        repeat (LAT + 10) @(negedge clk);
        #1;
        issue(32'd9, 32'd13, 32'd17);

        for (int v = 0; v < 400; v++) begin
            n = (v % 4 == 0) ? W'($urandom_range(1, 1000)) : ($urandom & 32'h7FFF_FFFF);
            if (n == 0) n = 1;
            a = $urandom % n;
            b = (v % 16 == 1) ? '0 : W'($urandom);
            issue(a, b, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
